// File: rtl/dram_arbiter.sv
// DRAM cycle sequencer and arbiter: fixed-length cycle timing plus per-cycle grant
// to refresh, CPU, video or (when ARB_DMA_EN is defined) DMA.
module dram_arbiter #(
    parameter int CYC_LEN    = 4,
    parameter int VID_MAX    = 3,
    parameter int REF_PERIOD = 64,
    parameter int REF_URGENT = 8
) (
    input  logic        fclk,
    input  logic        rst_n,
    output logic        cend,
    output logic        pre_cend,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [20:0] cpu_addr,
    input  logic [7:0]  cpu_wrdata,
    input  logic        cpu_wrbsel,
    output logic        cpu_strobe,
    input  logic        video_req,
    input  logic [20:0] video_addr,
    output logic        video_next,
    output logic        video_strobe,
    output logic        dram_req,
    output logic        dram_rnw,
    output logic        dram_rfsh,
    output logic [20:0] dram_addr,
    output logic [7:0]  dram_wrdata,
    output logic        dram_bsel,
    input  logic [15:0] dram_rddata
`ifdef ARB_DMA_EN
    ,
    input  logic        dma_req,
    input  logic        dma_rnw,
    input  logic [20:0] dma_addr,
    input  logic [7:0]  dma_wrdata,
    input  logic        dma_bsel,
    output logic        dma_next,
    output logic        dma_strobe
`endif
);

    localparam int CW = 4;
    localparam int RW = $clog2(REF_PERIOD);
    localparam int WW = $clog2(REF_URGENT + 1);
    localparam int VW = $clog2(VID_MAX + 1);

    localparam logic [CW-1:0] CYC_LAST = CW'(CYC_LEN - 1);
    localparam logic [CW-1:0] CYC_PRE  = CW'(CYC_LEN - 2);
    localparam logic [CW-1:0] CYC_PRE2 = CW'(CYC_LEN - 3);
    localparam logic [RW-1:0] REF_LAST = RW'(REF_PERIOD - 1);
    localparam logic [WW-1:0] WAIT_LIM = WW'(REF_URGENT);
    localparam logic [VW-1:0] VID_LIM  = VW'(VID_MAX);

    localparam logic [2:0] G_IDLE = 3'd0;
    localparam logic [2:0] G_REF  = 3'd1;
    localparam logic [2:0] G_CPU  = 3'd2;
    localparam logic [2:0] G_VID  = 3'd3;
`ifdef ARB_DMA_EN
    localparam logic [2:0] G_DMA  = 3'd4;
`endif

    logic [CW-1:0] cyc_cnt;
    logic [RW-1:0] ref_cnt;
    logic [WW-1:0] ref_wait;
    logic [VW-1:0] vid_run;
    logic          ref_due;
    logic          cpu_pend;
    logic          cpu_l_rnw;
    logic [20:0]   cpu_l_addr;
    logic [7:0]    cpu_l_wrdata;
    logic          cpu_l_bsel;
    logic          own_cpu_rd;
    logic          own_vid;
`ifdef ARB_DMA_EN
    logic          own_dma_rd;
`endif

    logic          cpu_new;
    logic          cpu_wait;
    logic          sel_rnw;
    logic [20:0]   sel_addr;
    logic [7:0]    sel_wrdata;
    logic          sel_bsel;
    logic          urgent;
    logic [2:0]    grant;

    // Read data goes straight from the controller to the requesters.
    logic unused_rddata;
    assign unused_rddata = ^dram_rddata;

    // A request captured at this cend can win this very cend, so it is muxed in directly.
    always_comb begin
        cpu_new    = cend && cpu_req && !cpu_pend;
        cpu_wait   = cpu_pend || cpu_new;
        sel_rnw    = cpu_new ? cpu_rnw    : cpu_l_rnw;
        sel_addr   = cpu_new ? cpu_addr   : cpu_l_addr;
        sel_wrdata = cpu_new ? cpu_wrdata : cpu_l_wrdata;
        sel_bsel   = cpu_new ? cpu_wrbsel : cpu_l_bsel;
        urgent     = ref_due && (ref_wait >= WAIT_LIM);

        grant = G_IDLE;
        if (urgent)
            grant = G_REF;
        else if (cpu_pend && (vid_run >= VID_LIM))
            grant = G_CPU;
        else if (video_req)
            grant = G_VID;
        else if (cpu_wait)
            grant = G_CPU;
        else if (ref_due)
            grant = G_REF;
`ifdef ARB_DMA_EN
        else if (dma_req)
            grant = G_DMA;
`endif
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt      <= '0;
            cend         <= 1'b0;
            pre_cend     <= 1'b0;
            ref_cnt      <= '0;
            ref_wait     <= '0;
            ref_due      <= 1'b0;
            vid_run      <= '0;
            cpu_pend     <= 1'b0;
            cpu_l_rnw    <= 1'b0;
            cpu_l_addr   <= '0;
            cpu_l_wrdata <= '0;
            cpu_l_bsel   <= 1'b0;
            own_cpu_rd   <= 1'b0;
            own_vid      <= 1'b0;
            cpu_strobe   <= 1'b0;
            video_strobe <= 1'b0;
            video_next   <= 1'b0;
            dram_req     <= 1'b0;
            dram_rnw     <= 1'b1;
            dram_rfsh    <= 1'b0;
            dram_addr    <= '0;
            dram_wrdata  <= '0;
            dram_bsel    <= 1'b0;
`ifdef ARB_DMA_EN
            own_dma_rd   <= 1'b0;
            dma_next     <= 1'b0;
            dma_strobe   <= 1'b0;
`endif
        end else begin
            cyc_cnt      <= (cyc_cnt == CYC_LAST) ? '0 : cyc_cnt + 1'b1;
            pre_cend     <= (cyc_cnt == CYC_PRE2);
            cend         <= (cyc_cnt == CYC_PRE);
            cpu_strobe   <= (cyc_cnt == CYC_PRE) && own_cpu_rd;
            video_strobe <= (cyc_cnt == CYC_PRE) && own_vid;
            dram_req     <= 1'b0;
            dram_rfsh    <= 1'b0;
            video_next   <= 1'b0;
`ifdef ARB_DMA_EN
            dma_strobe   <= (cyc_cnt == CYC_PRE) && own_dma_rd;
            dma_next     <= 1'b0;
`endif

            if (cend) begin
                if (cpu_new) begin
                    cpu_l_rnw    <= cpu_rnw;
                    cpu_l_addr   <= cpu_addr;
                    cpu_l_wrdata <= cpu_wrdata;
                    cpu_l_bsel   <= cpu_wrbsel;
                end
                cpu_pend <= cpu_wait && (grant != G_CPU);

                if ((grant == G_VID) && cpu_wait)
                    vid_run <= (vid_run == VID_LIM) ? vid_run : vid_run + 1'b1;
                else
                    vid_run <= '0;

                // A wrap on the same cend as a refresh grant must leave ref_due set.
                if (grant == G_REF) begin
                    ref_due  <= 1'b0;
                    ref_wait <= '0;
                end else if (ref_due && (ref_wait != WAIT_LIM)) begin
                    ref_wait <= ref_wait + 1'b1;
                end
                if (ref_cnt == REF_LAST) begin
                    ref_cnt <= '0;
                    ref_due <= 1'b1;
                end else begin
                    ref_cnt <= ref_cnt + 1'b1;
                end

                own_cpu_rd <= 1'b0;
                own_vid    <= 1'b0;
`ifdef ARB_DMA_EN
                own_dma_rd <= 1'b0;
`endif
                case (grant)
                    G_REF: begin
                        dram_req  <= 1'b1;
                        dram_rfsh <= 1'b1;
                        dram_rnw  <= 1'b1;
                    end
                    G_CPU: begin
                        dram_req    <= 1'b1;
                        dram_rnw    <= sel_rnw;
                        dram_addr   <= sel_addr;
                        dram_wrdata <= sel_wrdata;
                        dram_bsel   <= sel_bsel;
                        own_cpu_rd  <= sel_rnw;
                    end
                    G_VID: begin
                        dram_req   <= 1'b1;
                        dram_rnw   <= 1'b1;
                        dram_addr  <= video_addr;
                        video_next <= 1'b1;
                        own_vid    <= 1'b1;
                    end
`ifdef ARB_DMA_EN
                    G_DMA: begin
                        dram_req    <= 1'b1;
                        dram_rnw    <= dma_rnw;
                        dram_addr   <= dma_addr;
                        dram_wrdata <= dma_wrdata;
                        dram_bsel   <= dma_bsel;
                        dma_next    <= 1'b1;
                        own_dma_rd  <= dma_rnw;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Randomised bench for dram_arbiter (default build) against a DRAM-cycle-level model.
module tb_dram_arbiter;

    localparam int CYC_LEN    = 4;
    localparam int VID_MAX    = 3;
    localparam int REF_PERIOD = 64;
    localparam int REF_URGENT = 8;

    logic        fclk = 1'b0;
    logic        rst_n;
    logic        cend, pre_cend;
    logic        cpu_req, cpu_rnw, cpu_wrbsel, cpu_strobe;
    logic [20:0] cpu_addr;
    logic [7:0]  cpu_wrdata;
    logic        video_req, video_next, video_strobe;
    logic [20:0] video_addr;
    logic        dram_req, dram_rnw, dram_rfsh, dram_bsel;
    logic [20:0] dram_addr;
    logic [7:0]  dram_wrdata;
    logic [15:0] dram_rddata;

    always #5 fclk = ~fclk;

    dram_arbiter #(
        .CYC_LEN(CYC_LEN), .VID_MAX(VID_MAX),
        .REF_PERIOD(REF_PERIOD), .REF_URGENT(REF_URGENT)
    ) dut (
        .fclk(fclk), .rst_n(rst_n), .cend(cend), .pre_cend(pre_cend),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
        .cpu_wrdata(cpu_wrdata), .cpu_wrbsel(cpu_wrbsel), .cpu_strobe(cpu_strobe),
        .video_req(video_req), .video_addr(video_addr),
        .video_next(video_next), .video_strobe(video_strobe),
        .dram_req(dram_req), .dram_rnw(dram_rnw), .dram_rfsh(dram_rfsh),
        .dram_addr(dram_addr), .dram_wrdata(dram_wrdata), .dram_bsel(dram_bsel),
        .dram_rddata(dram_rddata)
    );

    int checks = 0;
    int errors = 0;
    int phase;
    int mode;
    bit inject;
    logic [20:0] inject_addr;

    // Model state, one step per DRAM cycle
    int          m_cends, m_wait, m_vrun, owner;
    bit          m_pend, m_due;
    logic        m_rnw, m_bsel;
    logic [20:0] m_addr;
    logic [7:0]  m_wr;
    bit          e_req, e_rfsh, e_vnext, e_cpuwr;
    logic        e_rnw, e_bsel;
    logic [20:0] e_addr;
    logic [7:0]  e_wr;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        phase = 0; m_cends = 0; m_wait = 0; m_vrun = 0; owner = 0;
        m_pend = 0; m_due = 0; m_rnw = 0; m_bsel = 0; m_addr = '0; m_wr = '0;
        e_req = 0; e_rfsh = 0; e_vnext = 0; e_cpuwr = 0;
        e_rnw = 1; e_bsel = 0; e_addr = '0; e_wr = '0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_cend", cend, 0);
        checkOutput("rst_pre_cend", pre_cend, 0);
        checkOutput("rst_dram_req", dram_req, 0);
        checkOutput("rst_dram_rnw", dram_rnw, 1);
        checkOutput("rst_dram_rfsh", dram_rfsh, 0);
        checkOutput("rst_dram_addr", dram_addr, 0);
        checkOutput("rst_dram_wrdata", dram_wrdata, 0);
        checkOutput("rst_dram_bsel", dram_bsel, 0);
        checkOutput("rst_cpu_strobe", cpu_strobe, 0);
        checkOutput("rst_video_next", video_next, 0);
        checkOutput("rst_video_strobe", video_strobe, 0);
    endtask

    // Inputs for the cend currently on the bus; cpu_req lasts only this cend.
    task automatic applyStimulus();
        cpu_rnw    = 1'($urandom);
        cpu_addr   = 21'($urandom);
        cpu_wrdata = 8'($urandom);
        cpu_wrbsel = 1'($urandom);
        video_addr = 21'($urandom);
        case (mode)
            1:       begin cpu_req = ($urandom_range(0, 2) == 0); video_req = 1'($urandom); end
            2:       begin cpu_req = 1'($urandom); video_req = 1'b1; end
            3:       begin cpu_req = 1'b0; video_req = 1'b1; end
            default: begin cpu_req = 1'b0; video_req = 1'b0; end
        endcase
        if (inject) begin
            cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = inject_addr; inject = 0;
        end
    endtask

    // Winner by priority list: 0 idle, 1 refresh, 2 cpu, 3 video
    task automatic modelCend();
        bit new_cap, waiting, urgent;
        int win;
        m_cends++;
        new_cap = cpu_req && !m_pend;
        if (new_cap) begin
            m_rnw = cpu_rnw; m_addr = cpu_addr; m_wr = cpu_wrdata; m_bsel = cpu_wrbsel;
        end
        waiting = m_pend || new_cap;
        urgent  = m_due && (m_wait >= REF_URGENT);
        if (urgent)                          win = 1;
        else if (m_pend && m_vrun >= VID_MAX) win = 2;
        else if (video_req)                  win = 3;
        else if (waiting)                    win = 2;
        else if (m_due)                      win = 1;
        else                                 win = 0;

        if (win == 1) begin m_due = 0; m_wait = 0; end
        else if (m_due) m_wait++;
        if (m_cends % REF_PERIOD == 0) m_due = 1;
        m_vrun = (win == 3 && waiting) ? m_vrun + 1 : 0;
        m_pend = waiting && (win != 2);

        e_req   = (win != 0);
        e_rfsh  = (win == 1);
        e_vnext = (win == 3);
        e_cpuwr = (win == 2) && !m_rnw;
        owner   = (win == 2 && m_rnw) ? 1 : (win == 3) ? 2 : 0;
        if (win == 2) begin e_addr = m_addr; e_rnw = m_rnw; e_wr = m_wr; e_bsel = m_bsel; end
        if (win == 3) begin e_addr = video_addr; e_rnw = 1'b1; end
    endtask

    task automatic tick();
        @(negedge fclk);
        phase = (phase + 1) % CYC_LEN;
        checkOutput("cend", cend, phase == CYC_LEN - 1);
        checkOutput("pre_cend", pre_cend, phase == CYC_LEN - 2);
        checkOutput("dram_req", dram_req, phase == 0 && e_req);
        checkOutput("dram_rfsh", dram_rfsh, phase == 0 && e_rfsh);
        checkOutput("video_next", video_next, phase == 0 && e_vnext);
        checkOutput("cpu_strobe", cpu_strobe, phase == CYC_LEN - 1 && owner == 1);
        checkOutput("video_strobe", video_strobe, phase == CYC_LEN - 1 && owner == 2);
        if ((phase == 0 || phase == 2) && e_req && !e_rfsh) begin
            checkOutput("dram_addr", dram_addr, e_addr);
            checkOutput("dram_rnw", dram_rnw, e_rnw);
            if (e_cpuwr) begin
                checkOutput("dram_wrdata", dram_wrdata, e_wr);
                checkOutput("dram_bsel", dram_bsel, e_bsel);
            end
        end
        if (phase == 0 && e_rfsh)
            checkOutput("rfsh_rnw", dram_rnw, 1);
        cpu_req = 1'b0;
        if (phase == CYC_LEN - 1) begin
            applyStimulus();
            modelCend();
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        cpu_req = 0; cpu_rnw = 0; cpu_addr = '0; cpu_wrdata = '0; cpu_wrbsel = 0;
        video_req = 0; video_addr = '0;
        repeat (2) @(negedge fclk);
        checkResetState();
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        dram_rddata = 16'hA5C3;
        rst_n = 1'b1;
        inject = 0;
        inject_addr = '0;
        mode = 0;
        #2;
        doReset();

        mode = 0;
        repeat (20) tick();

        inject_addr = 21'h12345;
        inject = 1;
        repeat (12) tick();

        mode = 2;
        repeat (200) tick();
        mode = 0;
        repeat (280) tick();
        mode = 3;
        repeat (300) tick();
        mode = 1;
        repeat (1200) tick();

        // Abort a CPU read one fclk into its DRAM cycle
        mode = 0;
        repeat (12) tick();
        inject_addr = 21'h1ABCD;
        inject = 1;
        for (int i = 0; i < 8 && inject; i++) tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkResetState();
        repeat (2) @(negedge fclk);
        rst_n = 1'b1;
        modelReset();
        repeat (40) tick();
        mode = 1;
        repeat (200) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
